bcd_updown_counter: RTL
=======================

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter DIGITS, default 4, sets the number of cascaded BCD digits; legal range is 1..8.
REQ-002 Parameter WRAP, default 1: 1 = wrap at terminal count; 0 = saturate at terminal count.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  is the reset, synchronous and active-high.
REQ-005 Port en  input  1  is the count enable.
REQ-006 Port load  input  1  is the synchronous parallel-load strobe.
REQ-007 Port up  input  1  is the direction: 1 = count up, 0 = count down.
REQ-008 Port d  input  4*DIGITS  is the load value; digit k occupies bits [4k+3:4k]; digit 0 is least significant.
REQ-009 Port q  output  4*DIGITS  is the registered BCD count, using the same digit packing as d.
REQ-010 Port cout  output  1  is the carry/borrow: combinational, asserted while a count step at terminal count is pending.
REQ-011 Port tc  output  1  is the terminal-count flag: combinational; q equals all 9s when up=1, or all 0s when up=0.

Function
REQ-012 Priority per clock edge SHALL be rst > load > en; with none of these asserted, q holds.
REQ-013 When load=1, q SHALL take d on the next edge, regardless of en and up.
REQ-014 Any loaded digit with value greater than 9 SHALL be stored as 0; valid digits are unaffected.
REQ-015 Up counting with en=1 and load=0: digit 0 increments by 1. Digit k increments only when all lower digits are 9. Any digit at 9 that increments goes to 0.
REQ-016 Down counting with en=1 and load=0: digit 0 decrements by 1. Digit k decrements only when all lower digits are 0. Any digit at 0 that decrements goes to 9.
REQ-017 cout SHALL equal en & ~load & ~rst & tc.
REQ-018 When WRAP=1 and cout=1, q SHALL wrap: all 9s to all 0s going up; all 0s to all 9s going down.
REQ-019 When WRAP=0 and cout=1, q SHALL hold at the terminal value; cout still asserts for every enabled cycle spent at terminal count.
REQ-020 A change of up while en=1 SHALL take effect on the same edge; there is no pipeline delay.
REQ-021 Count latency SHALL be one clock: q reflects the step on the edge where en is sampled.
REQ-022 q SHALL never hold a non-BCD digit, whatever the input sequence.
REQ-023 When DIGITS=1, behaviour SHALL match a single mod-10 up/down counter.

Reset
REQ-024 On a clock edge with rst=1, q SHALL become all zeros; this overrides load and en.
REQ-025 After reset, with up=1 the outputs SHALL be tc=0 and cout=0; with up=0 they SHALL be tc=1 and cout=0, since cout is gated by rst.
REQ-026 Reset asserted mid-count SHALL clear all digits on that edge; no partial cascade completes.
REQ-027 The block SHALL have no asynchronous state and no initial-value dependence beyond reset.

Structure
REQ-028 Shared package bcd_pkg SHALL hold DIGIT_W=4, DIGIT_MAX=4'd9 and DIGIT_MIN=4'd0.
REQ-029 A one-digit sub-module bcd_digit SHALL be instantiated DIGITS times through a generate loop.
REQ-030 Each bcd_digit SHALL have these ports: clk, rst, load, ld_val, step, up, q_dig, at_max, at_min.
REQ-031 Each digit's step input SHALL be formed from en, ~load and the AND of lower-digit at_max (up) or at_min (down) flags.
REQ-032 tc SHALL be the AND of all at_max flags (up) or all at_min flags (down).

Verification
REQ-033 Wrap-up: DIGITS=2, WRAP=1, rst then load d=8'h98, en=1, up=1 -> q = 98, 99, 00, 01; cout=1 only in the cycle q=99.
REQ-034 Wrap-down: DIGITS=2, WRAP=1, load 8'h01, up=0, en=1 -> q = 01, 00, 99, 98; cout=1 only in the cycle q=00.
REQ-035 Saturate: DIGITS=2, WRAP=0, load 8'h98, up=1, en=1 for 4 cycles -> q = 98, 99, 99, 99; cout=1 in every cycle at 99.
REQ-036 Priority and invalid load: q=37, assert load=1, en=1, d=8'hA5 -> q=05 next edge; assert rst=1 with load=1 -> q=00.
REQ-037 Direction flip: DIGITS=4 at q=0100, en=1, up=1 then up=0 on the next cycle -> q = 0100, 0101, 0100; cout stays 0 throughout.
REQ-038 Full-period check: DIGITS=3, up=1, en=1 for 1000 cycles from 000 -> q returns to 000; cout pulses exactly once; no non-BCD digit is ever seen.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit constants and load-value sanitising helper.
package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] DIGIT_MIN = 4'd0;
  function automatic logic [DIGIT_W-1:0] sanitize(input logic [DIGIT_W-1:0] v);
    return (v > DIGIT_MAX) ? DIGIT_MIN : v;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one mod-10 up/down digit with sync load and terminal flags.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DIGIT_W-1:0] ld_val,
  input  logic               step,
  input  logic               up,
  output logic [DIGIT_W-1:0] q_dig,
  output logic               at_max,
  output logic               at_min
);
  logic [DIGIT_W-1:0] q_q, q_d;
  assign at_max = (q_q == DIGIT_MAX);
  assign at_min = (q_q == DIGIT_MIN);
  assign q_dig  = q_q;
  // >= rather than == keeps the digit self-correcting toward valid BCD
  always_comb begin
    q_d = load  ? sanitize(ld_val) :
          !step ? q_q :
          up    ? ((q_q >= DIGIT_MAX) ? DIGIT_MIN : q_q + 4'd1) :
                  (at_min ? DIGIT_MAX : q_q - 4'd1);
  end
  always_ff @(posedge clk) begin
    if (rst) q_q <= DIGIT_MIN;
    else     q_q <= q_d;
  end
endmodule

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: cascaded DIGITS-digit BCD up/down counter with load, wrap or saturate.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      load,
  input  logic                      up,
  input  logic [DIGIT_W*DIGITS-1:0] d,
  output logic [DIGIT_W*DIGITS-1:0] q,
  output logic                      cout,
  output logic                      tc
);
  logic [DIGITS-1:0] at_max, at_min, flag, step;
  logic [DIGITS:0]   run;
  logic              adv;
  assign flag   = up ? at_max : at_min;
  assign run[0] = 1'b1;
  assign tc     = run[DIGITS];
  assign cout   = en & ~load & ~rst & tc;
  // saturating variant freezes every digit while parked at terminal count
  assign adv    = en & ~load & ~(cout & ~WRAP);
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    assign run[k+1] = run[k] & flag[k];
    assign step[k]  = adv & run[k];
    bcd_digit u_dig (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .ld_val (d[DIGIT_W*k +: DIGIT_W]),
      .step   (step[k]),
      .up     (up),
      .q_dig  (q[DIGIT_W*k +: DIGIT_W]),
      .at_max (at_max[k]),
      .at_min (at_min[k])
    );
  end
endmodule
